// File: rtl/mem_access_unit.sv
// Load/store front-end for a synchronous byte-enabled block RAM.
// Optional build macro: MAU_ALIGN_CHECK_EN (misaligned half/word accesses become errors).
module mem_access_unit #(
  parameter int RAM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] resp_badaddr,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              ld_sgn_q, ld_sgn_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] bad_q, bad_d;

  logic              accept;
  logic              req_err;
  logic [1:0]        eff_off;
  logic [31:0]       rd_sh;
  logic [31:0]       rd_fmt;

  // Lane offset with low bits that a half/word cannot address forced to zero.
  always_comb begin
    case (req_size)
      2'd0:    eff_off = req_addr[1:0];
      2'd1:    eff_off = {req_addr[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
  end

`ifdef MAU_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = ((req_size == 2'd1) && req_addr[0]) ||
                    ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign req_err  = (req_size == 2'd3) || misalign;
`else
  assign req_err  = (req_size == 2'd3);
`endif

  assign req_ready  = resetn && (state_q == S_IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;
  assign resp_badaddr = bad_q;

  assign rd_sh = ram_rdata >> {ld_off_q, 3'b000};
  always_comb begin
    case (ld_size_q)
      2'd0:    rd_fmt = {{24{ld_sgn_q & rd_sh[7]}}, rd_sh[7:0]};
      2'd1:    rd_fmt = {{16{ld_sgn_q & rd_sh[15]}}, rd_sh[15:0]};
      default: rd_fmt = ram_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_off_d  = ld_off_q;
    ld_size_d = ld_size_q;
    ld_sgn_d  = ld_sgn_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    bad_d     = bad_q;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err) begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
            bad_d   = req_addr;
            state_d = S_RESP;
          end else begin
            ram_en   = 1'b1;
            ram_addr = {2'b00, req_addr[ADDR_W-1:2]};
            err_d    = 1'b0;
            bad_d    = '0;
            if (req_we) begin
              case (req_size)
                2'd0: begin
                  ram_we    = 4'b0001 << eff_off;
                  ram_wdata = {4{req_wdata[7:0]}};
                end
                2'd1: begin
                  ram_we    = 4'b0011 << eff_off;
                  ram_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                  ram_we    = 4'b1111;
                  ram_wdata = req_wdata;
                end
              endcase
              rdata_d = 32'h0;
              state_d = S_RESP;
            end else begin
              ld_off_d  = eff_off;
              ld_size_d = req_size;
              ld_sgn_d  = req_signed;
              cnt_d     = 3'(RAM_LATENCY);
              state_d   = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        // Counter hits zero on this edge: RAM data is valid now.
        if (cnt_q == 3'd1) begin
          rdata_d = rd_fmt;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      ld_off_q  <= 2'd0;
      ld_size_q <= 2'd0;
      ld_sgn_q  <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      bad_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_off_q  <= ld_off_d;
      ld_size_q <= ld_size_d;
      ld_sgn_q  <= ld_sgn_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      bad_q     <= bad_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: unit 0 at RAM_LATENCY=1, unit 1 at RAM_LATENCY=3, each with a RAM model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rstn, req_valid, req_ready, req_we, req_signed;
  logic [1:0]       resp_valid, resp_err, ram_en;
  logic [1:0][1:0]  req_size;
  logic [1:0][3:0]  ram_we;
  logic [1:0][31:0] req_addr, req_wdata, resp_rdata, resp_badaddr;
  logic [1:0][31:0] ram_addr, ram_wdata, ram_rdata;

  for (genvar g = 0; g < 2; g++) begin : u_g
    localparam int LAT = (g == 0) ? 1 : 3;
    mem_access_unit #(.RAM_LATENCY(LAT), .ADDR_W(32)) dut (
      .clk(clk), .resetn(rstn[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_size(req_size[g]), .req_signed(req_signed[g]), .req_addr(req_addr[g]),
      .req_wdata(req_wdata[g]), .resp_valid(resp_valid[g]), .resp_rdata(resp_rdata[g]),
      .resp_err(resp_err[g]), .resp_badaddr(resp_badaddr[g]), .ram_en(ram_en[g]),
      .ram_we(ram_we[g]), .ram_addr(ram_addr[g]), .ram_wdata(ram_wdata[g]),
      .ram_rdata(ram_rdata[g])
    );

    logic [31:0] mem  [256];
    logic [31:0] pipe [4];
    always @(posedge clk) begin
      if (ram_en[g]) begin
        for (int b = 0; b < 4; b++)
          if (ram_we[g][b]) mem[ram_addr[g][7:0]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
        pipe[0] <= mem[ram_addr[g][7:0]];
      end
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign ram_rdata[g] = pipe[LAT-1];
  end

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic [31:0] bad;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input int u, input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_en, input logic [3:0] exp_we, input logic [31:0] exp_wd,
                        input int lat, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int cyc;
    @(posedge clk); #1;
    check("idle_ready", 32'(req_ready[u]), 32'd1);
    check("idle_no_resp", 32'(resp_valid[u]), 32'd0);
    req_valid[u] = 1'b1; req_we[u] = we; req_size[u] = sz; req_signed[u] = sg;
    req_addr[u] = a; req_wdata[u] = wd;
    #1;
    check("ram_en", 32'(ram_en[u]), 32'(exp_en));
    check("ram_we", 32'(ram_we[u]), 32'(exp_we));
    if (exp_en) check("ram_addr", ram_addr[u], {2'b00, a[31:2]});
    if (exp_en && we) check("ram_wdata", ram_wdata[u], exp_wd);
    e.rd = exp_rd; e.err = exp_err; e.bad = exp_err ? a : 32'h0; e.lat = lat;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    cyc = 1;
    while (!resp_valid[u] && cyc < 12) begin
      check("stall_ready", 32'(req_ready[u]), 32'd0);
      check("stall_ram_en", 32'(ram_en[u]), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check("resp_seen", 32'(resp_valid[u]), 32'd1);
    e = sb.pop_front();
    check("latency", 32'(cyc), 32'(e.lat));
    check("resp_ready", 32'(req_ready[u]), 32'd0);
    check("resp_rdata", resp_rdata[u], e.rd);
    check("resp_err", 32'(resp_err[u]), 32'(e.err));
    if (e.err) check("resp_badaddr", resp_badaddr[u], e.bad);
  endtask

  initial begin
    rstn = 2'b00; req_valid = '0; req_we = '0; req_signed = '0;
    req_size = '0; req_addr = '0; req_wdata = '0;
    #1;
    for (int u = 0; u < 2; u++) begin
      check("rst_ready", 32'(req_ready[u]), 32'd0);
      check("rst_resp_valid", 32'(resp_valid[u]), 32'd0);
      check("rst_rdata", resp_rdata[u], 32'h0);
      check("rst_err", 32'(resp_err[u]), 32'd0);
      check("rst_ram_en", 32'(ram_en[u]), 32'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 2'b11;
    #1;
    check("rel_ready0", 32'(req_ready[0]), 32'd1);
    check("rel_ready1", 32'(req_ready[1]), 32'd1);

    // Unit 0, RAM_LATENCY=1
    do_req(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, 1, 32'h0, 0);
    do_req(0, 1, 2'd0, 0, 32'h13, 32'h000000A5, 1, 4'b1000, 32'hA5A5A5A5, 1, 32'h0, 0);
    do_req(0, 0, 2'd2, 0, 32'h10, 32'h0, 1, 4'b0000, 32'h0, 2, 32'hA5ADBEEF, 0);
    do_req(0, 0, 2'd0, 1, 32'h13, 32'h0, 1, 4'b0000, 32'h0, 2, 32'hFFFFFFA5, 0);
    do_req(0, 0, 2'd0, 0, 32'h13, 32'h0, 1, 4'b0000, 32'h0, 2, 32'h000000A5, 0);
    do_req(0, 0, 2'd1, 1, 32'h12, 32'h0, 1, 4'b0000, 32'h0, 2, 32'hFFFFA5AD, 0);
    do_req(0, 0, 2'd1, 0, 32'h10, 32'h0, 1, 4'b0000, 32'h0, 2, 32'h0000BEEF, 0);
    do_req(0, 0, 2'd0, 1, 32'h11, 32'h0, 1, 4'b0000, 32'h0, 2, 32'hFFFFFFBE, 0);
`ifdef MAU_ALIGN_CHECK_EN
    do_req(0, 0, 2'd1, 1, 32'h11, 32'h0, 0, 4'b0000, 32'h0, 1, 32'h0, 1);
    do_req(0, 0, 2'd2, 0, 32'h12, 32'h0, 0, 4'b0000, 32'h0, 1, 32'h0, 1);
`else
    do_req(0, 0, 2'd1, 1, 32'h11, 32'h0, 1, 4'b0000, 32'h0, 2, 32'hFFFFBEEF, 0);
    do_req(0, 0, 2'd2, 0, 32'h12, 32'h0, 1, 4'b0000, 32'h0, 2, 32'hA5ADBEEF, 0);
`endif
    do_req(0, 1, 2'd3, 0, 32'h14, 32'h12345678, 0, 4'b0000, 32'h0, 1, 32'h0, 1);
    do_req(0, 1, 2'd2, 0, 32'h14, 32'h00000000, 1, 4'b1111, 32'h00000000, 1, 32'h0, 0);
    do_req(0, 1, 2'd1, 0, 32'h16, 32'h12345678, 1, 4'b1100, 32'h56785678, 1, 32'h0, 0);
    do_req(0, 0, 2'd2, 0, 32'h14, 32'h0, 1, 4'b0000, 32'h0, 2, 32'h56780000, 0);

    // Unit 1, RAM_LATENCY=3
    do_req(1, 1, 2'd2, 0, 32'h20, 32'h800000FF, 1, 4'b1111, 32'h800000FF, 1, 32'h0, 0);
    do_req(1, 0, 2'd0, 1, 32'h20, 32'h0, 1, 4'b0000, 32'h0, 4, 32'hFFFFFFFF, 0);
    do_req(1, 0, 2'd1, 0, 32'h22, 32'h0, 1, 4'b0000, 32'h0, 4, 32'h00008000, 0);
    do_req(1, 0, 2'd3, 0, 32'h24, 32'h0, 0, 4'b0000, 32'h0, 1, 32'h0, 1);

    // Reset in cycle 2 of a load: pending data discarded, outputs cleared.
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'd0; req_signed[1] = 1'b1;
    req_addr[1] = 32'h20;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rstn[1] = 1'b0;
    #1;
    check("mid_rst_resp_valid", 32'(resp_valid[1]), 32'd0);
    check("mid_rst_rdata", resp_rdata[1], 32'h0);
    check("mid_rst_err", 32'(resp_err[1]), 32'd0);
    check("mid_rst_badaddr", resp_badaddr[1], 32'h0);
    check("mid_rst_ram_en", 32'(ram_en[1]), 32'd0);
    check("mid_rst_ram_we", 32'(ram_we[1]), 32'd0);
    check("mid_rst_ready", 32'(req_ready[1]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_resp", 32'(resp_valid[1]), 32'd0);
    end
    do_req(1, 1, 2'd2, 0, 32'h28, 32'h11223344, 1, 4'b1111, 32'h11223344, 1, 32'h0, 0);
    do_req(1, 0, 2'd2, 0, 32'h28, 32'h0, 1, 4'b0000, 32'h0, 4, 32'h11223344, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front-end sitting directly upstream of the synchronous block RAM (data RAM port: clka/ena/wea/addra/dina/douta). Accepts one access per transaction from the MEM pipeline stage, generates word address, byte write enables and lane-replicated store data. Absorbs the RAM read latency, then returns aligned, sign/zero-extended load data. Stalls the pipeline via req_ready while a transaction is in flight.

Parameters:
RAM_LATENCY, 1, cycles from ram_en sampled to ram_rdata valid (1..4)
ADDR_W, 32, byte address width and RAM address width

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  1  MEM stage presents an access
req_ready  out  1  unit can accept; transfer when req_valid & req_ready
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_signed  in  1  load sign-extend (1) / zero-extend (0)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle pulse: transaction complete
resp_rdata  out  32  formatted load data (0 for stores/errors)
resp_err  out  1  address/size error, qualified by resp_valid
resp_badaddr  out  ADDR_W  faulting req_addr, qualified by resp_err
ram_en  out  1  RAM enable (ena)
ram_we  out  4  RAM byte write enables (wea)
ram_addr  out  ADDR_W  RAM word address = {2'b00, req_addr[ADDR_W-1:2]}
ram_wdata  out  32  RAM write data (dina)
ram_rdata  in  32  RAM read data (douta)

Behaviour:
- Reset (async, resetn=0): state IDLE; req_ready=1 once released; resp_valid=0, resp_rdata=0, resp_err=0, resp_badaddr=0; ram_en=0, ram_we=0, latency counter=0. Reset mid-transaction discards pending RAM data; no resp_valid is issued for it.
- States: IDLE, WAIT, RESP. req_ready=1 only in IDLE.
- IDLE: on accept: error -> RESP (no RAM access); store -> RAM write this cycle, -> RESP; load -> RAM read this cycle, counter=RAM_LATENCY, -> WAIT.
- ram_en/ram_we/ram_addr/ram_wdata are combinational from req_* in the accept cycle only; otherwise ram_en=0, ram_we=0.
- WAIT: counter decrements each cycle; on reaching 0, capture ram_rdata, format, -> RESP.
- RESP: resp_valid=1 for exactly one cycle, outputs registered; -> IDLE. resp_rdata/resp_err hold until next RESP.
- Latency (accept cycle = 0): store/error resp_valid in cycle 1; load in cycle RAM_LATENCY+1. Next accept earliest in cycle after RESP.
- Byte lanes little-endian by req_addr[1:0]. Store byte: ram_we = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}; half: ram_we = 4'b0011 << {addr[1],1'b0}, wdata = {2{wdata[15:0]}}; word: 4'b1111, wdata unchanged.
- Load: select lane by latched addr[1:0], extend per latched req_signed to 32 bits; word ignores req_signed.
- req_size=3: always error (resp_err=1, no RAM access), independent of macro.
- req_valid while not ready: ignored, inputs not sampled.

Optional Feature:
MAU_ALIGN_CHECK_EN - defined: half with addr[0]=1 or word with addr[1:0]!=0 -> error path, resp_err=1, resp_badaddr=req_addr, no RAM access. Undefined: misalignment never errors; offending low address bits forced to 0 for lane/enable selection (half ignores addr[0], word ignores addr[1:0]).

Test Plan:
- Store word 0xDEADBEEF @0x10 -> accept cycle ram_en=1, ram_we=4'b1111, ram_addr=0x4, ram_wdata=0xDEADBEEF; resp_valid cycle 1, resp_err=0.
- Store byte 0xA5 @0x13 -> ram_we=4'b1000, ram_wdata=0xA5A5A5A5; then load word @0x10 with RAM model (RAM_LATENCY=1) -> resp_valid cycle 2, resp_rdata=0xA5ADBEEF.
- Load byte signed @0x13 (mem 0xA5ADBEEF) -> 0xFFFFFFA5; unsigned -> 0x000000A5; half signed @0x12 -> 0xFFFFA5AD.
- Half load @0x11 with MAU_ALIGN_CHECK_EN -> no ram_en, resp_err=1, resp_badaddr=0x11 in cycle 1; without macro -> reads half @0x10 = 0xFFFFBEEF signed.
- RAM_LATENCY=3 load; req_ready=0 cycles 1-4, resp_valid only cycle 4; req_size=3 -> resp_err=1 in both builds.
- Assert resetn=0 in cycle 2 of a RAM_LATENCY=3 load -> all outputs 0 immediately, no resp_valid; after release, new store completes normally.
